// File: rtl/seg7_page_ctrl_pkg.sv
// Shared types and constants for the multi-page 7-segment display controller.
// Glyphs are active-low in GFEDCBA order (bit 6 = segment G, bit 0 = segment A).
package seg7_page_ctrl_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h7F;

  // Hex digit glyphs 0-9, A, b, C, d, E, F
  localparam seg7_t SEG7_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg7_t bcd_glyph(input bcd_t value);
    return SEG7_GLYPH[value];
  endfunction

  // Width of a page index; a single page still needs one bit
  function automatic int page_width(input int num_pages);
    return (num_pages > 1) ? $clog2(num_pages) : 1;
  endfunction

endpackage

// File: rtl/seg7_page_ctrl_if.sv
// Bundle of page data, masks, controls and display outputs for seg7_page_ctrl.
// master = producer side (clock/dcf77 glue), slave = display controller.
interface seg7_page_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_PAGES  = 4
);
  import seg7_page_ctrl_pkg::*;

  localparam int PW = page_width(NUM_PAGES);

  logic                                  clk_en;
  bcd_t [NUM_PAGES-1:0][NUM_DIGITS-1:0]  page_data;
  logic [NUM_PAGES-1:0][NUM_DIGITS-1:0]  page_blank;
  logic [NUM_PAGES-1:0][NUM_DIGITS-1:0]  page_blink;
  logic [NUM_PAGES-1:0]                  page_sel;
  logic                                  hold;
  seg7_t [NUM_DIGITS-1:0]                hex;
  logic [PW-1:0]                         page;
  logic                                  auto_mode;

  modport master (
    output clk_en, page_data, page_blank, page_blink, page_sel, hold,
    input  hex, page, auto_mode
  );

  modport slave (
    input  clk_en, page_data, page_blank, page_blink, page_sel, hold,
    output hex, page, auto_mode
  );

endinterface

// File: rtl/seg7_page_ctrl_tick_counter.sv
// Modulo-MOD counter advanced by an enable pulse, with synchronous clear.
// wrap is high in the enabled cycle where the count rolls over to zero.
module tick_counter #(
  parameter int MOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int CW = (MOD > 1) ? $clog2(MOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  logic [CW-1:0] cnt;

  assign wrap = en & (cnt == LAST);

  // Count enabled ticks, clear has priority over counting
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_page_ctrl.sv
// Multi-page 7-segment display controller: manual page select or timed
// auto-rotation, per-digit blank/blink masks, registered hex/page/auto_mode.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_page_ctrl
  import seg7_page_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int NUM_PAGES   = 4,
  parameter int DWELL_TICKS = 300,
  parameter int BLINK_TICKS = 50
) (
  input logic            clk,
  input logic            rst,
  seg7_page_ctrl_if.slave bus
);

  localparam int PW = page_width(NUM_PAGES);
  localparam logic [PW-1:0] LAST_PAGE = PW'(NUM_PAGES - 1);

  logic                   manual;
  logic                   dwell_wrap;
  logic                   blink_wrap;
  logic                   page_change;
  logic [PW-1:0]          page_q;
  logic [PW-1:0]          page_next;
  logic                   auto_q;
  logic                   blink_on;
  seg7_t [NUM_DIGITS-1:0] hex_next;
  seg7_t [NUM_DIGITS-1:0] hex_q;
  bcd_t                   digit;
  logic                   dark;
`ifdef SEG7_LZ_BLANK_EN
  logic                   lead;
`endif

  // Any set select bit forces manual mode; the lowest set bit picks the page
  assign manual = |bus.page_sel;

  function automatic logic [PW-1:0] lowest_set(input logic [NUM_PAGES-1:0] sel);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = NUM_PAGES - 1; i >= 0; i--) begin
      if (sel[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  // Dwell timer runs only in auto mode and is frozen by hold; manual keeps it at zero
  tick_counter #(.MOD(DWELL_TICKS)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.clk_en & ~bus.hold & ~manual),
    .clr  (manual),
    .wrap (dwell_wrap)
  );

  // Blink phase timer restarts whenever the shown page changes
  tick_counter #(.MOD(BLINK_TICKS)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.clk_en),
    .clr  (page_change),
    .wrap (blink_wrap)
  );

  // Next page: manual select wins over a coincident dwell expiry
  always_comb begin
    page_next = page_q;
    if (manual) begin
      page_next = lowest_set(bus.page_sel);
    end else if (dwell_wrap) begin
      page_next = (page_q == LAST_PAGE) ? '0 : page_q + 1'b1;
    end
  end

  assign page_change = (page_next != page_q);

  // Page, mode and blink phase registers; a new page always starts visible
  always_ff @(posedge clk) begin
    if (rst) begin
      page_q   <= '0;
      auto_q   <= 1'b0;
      blink_on <= 1'b1;
    end else begin
      page_q <= page_next;
      auto_q <= ~manual;
      if (page_change) begin
        blink_on <= 1'b1;
      end else if (blink_wrap) begin
        blink_on <= ~blink_on;
      end
    end
  end

  // Decode the shown page, scanning from the most significant digit down
  always_comb begin
    hex_next = '0;
    digit    = '0;
    dark     = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    lead     = 1'b1;
`endif
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      digit = bus.page_data[page_q][d];
      dark  = bus.page_blank[page_q][d] | (bus.page_blink[page_q][d] & ~blink_on);
`ifdef SEG7_LZ_BLANK_EN
      if ((d != 0) && lead && ((digit == 4'd0) || bus.page_blank[page_q][d])) begin
        dark = 1'b1;
      end else begin
        lead = 1'b0;
      end
`endif
      hex_next[d] = dark ? SEG7_BLANK : bcd_glyph(digit);
    end
  end

  // Register the segment outputs one cycle behind the page register
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_q <= {NUM_DIGITS{SEG7_BLANK}};
    end else begin
      hex_q <= hex_next;
    end
  end

  assign bus.hex       = hex_q;
  assign bus.page      = page_q;
  assign bus.auto_mode = auto_q;

endmodule
